// File: rtl/nes_pkg.sv
// Shared NES bus definitions: CPU-visible register addresses and the OAM DMA state encoding.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to TRIG_ADDR halts the CPU and copies a 256-byte page to DEST_ADDR,
// one read/write pair per byte, with an optional alignment cycle depending on clock parity.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAMDMA_ADDR,
  parameter logic [15:0] DEST_ADDR = OAMDATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        dma_active,
  output logic        dma_done
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q, data_d;
  logic       parity_q;
  logic       done_q, done_d;

  // Next-state logic and the bus mux; IDLE is a transparent CPU pass-through.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    index_d    = index_q;
    data_d     = data_q;
    done_d     = 1'b0;
    bus_addr   = cpu_addr;
    bus_dout   = data_q;
    bus_we     = 1'b0;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;

    case (state_q)
      ST_IDLE: begin
        bus_dout   = cpu_dout;
        bus_we     = cpu_we;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (cpu_we && (cpu_addr == TRIG_ADDR)) begin
          page_d  = cpu_dout;
          index_d = 8'h00;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = parity_q ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        bus_addr = {page_q, index_q};
        data_d   = bus_din;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        bus_addr = DEST_ADDR;
        bus_we   = 1'b1;
        if (index_q == 8'hFF) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          // Index wraps within the page; it never carries into page.
          index_d = index_q + 8'd1;
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
      parity_q <= ~parity_q;
      done_q   <= done_d;
    end
  end

  assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a cycle-count model of the transfer checked every cycle, plus directed scenarios.
module tb_oam_dma;

  localparam logic [15:0] IDLE_ADDR = 16'h8000;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        dma_active;
  logic        dma_done;

  logic [7:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  oam_dma dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .cpu_rdy   (cpu_rdy),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_we    (bus_we),
    .bus_din   (bus_din),
    .dma_active(dma_active),
    .dma_done  (dma_done)
  );

  assign bus_din = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: transfer described by cycle offset k since the trigger edge.
  bit       m_act, m_done, m_par, m_align;
  int       m_k;
  logic [7:0] m_page;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= 1'b0; m_done <= 1'b0; m_par <= 1'b0;
      m_align <= 1'b0; m_k <= 0; m_page <= 8'h00;
    end else begin
      m_par  <= ~m_par;
      m_done <= 1'b0;
      if (m_act) begin
        if (m_k == 512 + int'(m_align)) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_k <= m_k + 1;
        end
      end else if (cpu_we && cpu_addr == 16'h4014) begin
        m_act   <= 1'b1;
        m_k     <= 0;
        m_page  <= cpu_dout;
        m_align <= ~m_par;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ewe, erdy, eact, edone, chk_d;
    int          j, n;
    if (cmp_en) begin
      ed = 8'h00; chk_d = 1'b0;
      edone = m_done;
      if (!m_act) begin
        ea = cpu_addr; ewe = cpu_we; ed = cpu_dout; chk_d = 1'b1;
        erdy = 1'b1; eact = 1'b0;
      end else begin
        erdy = 1'b0; eact = 1'b1;
        if (m_k <= int'(m_align)) begin
          ea = cpu_addr; ewe = 1'b0;
        end else begin
          j = m_k - 1 - int'(m_align);
          n = j / 2;
          if (j % 2 == 0) begin
            ea = {m_page, 8'(n)}; ewe = 1'b0;
          end else begin
            ea = 16'h2004; ewe = 1'b1; ed = mem[{m_page, 8'(n)}]; chk_d = 1'b1;
          end
        end
      end
      n_checks++;
      if (bus_addr !== ea || bus_we !== ewe || cpu_rdy !== erdy || dma_active !== eact ||
          dma_done !== edone || (chk_d && bus_dout !== ed)) begin
        n_fail++;
        $display("FAIL cycle t=%0t got addr=%h we=%b dout=%h rdy=%b act=%b done=%b exp addr=%h we=%b dout=%h rdy=%b act=%b done=%b",
                 $time, bus_addr, bus_we, bus_dout, cpu_rdy, dma_active, dma_done,
                 ea, ewe, ed, erdy, eact, edone);
      end
    end
  end

  // Transfer statistics for the literal expectations.
  int          halt_cnt, wr_cnt, rd_cnt, done_cnt, bad_page, oam_wr_any;
  logic [7:0]  first_byte, last_byte, exp_page;
  logic [15:0] last_rd;
  bit          touch0;

  task automatic clear_stats(input logic [7:0] pg);
    halt_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; bad_page = 0; oam_wr_any = 0;
    first_byte = 8'h00; last_byte = 8'h00; last_rd = 16'h0000; touch0 = 1'b0; exp_page = pg;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!cpu_rdy) halt_cnt++;
      if (dma_active && bus_we && bus_addr == 16'h2004) begin
        wr_cnt++;
        if (wr_cnt == 1) first_byte = bus_dout;
        last_byte = bus_dout;
      end
      if (dma_active && !bus_we && bus_addr != IDLE_ADDR) begin
        rd_cnt++;
        last_rd = bus_addr;
        if (bus_addr[15:8] != exp_page) bad_page++;
      end
      if (dma_active && bus_addr == 16'h0000) touch0 = 1'b1;
      if (dma_done) done_cnt++;
      if (bus_we && bus_addr == 16'h2004) oam_wr_any++;
    end
  end

  task automatic idle_cpu();
    cpu_we = 1'b0; cpu_addr = IDLE_ADDR; cpu_dout = 8'h00;
  endtask

  // Trigger so that the parity seen in HALT equals halt_par.
  task automatic trigger(input logic [7:0] pg, input bit halt_par);
    @(posedge clk); #1;
    while (m_par == halt_par) begin
      @(posedge clk); #1;
    end
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = pg;
    @(posedge clk); #1;
    clear_stats(pg);
    idle_cpu();
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (dma_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a] = av[7:0] ^ av[15:8];
    end
    for (int i = 0; i < 256; i++) mem[{8'hFF, 8'(i)}] = 8'(i);

    rst = 1'b1;
    idle_cpu();
    clear_stats(8'h00);
    #3 rst = 1'b0;
    cmp_en = 1'b1;
    #9;
    check("reset_rdy", 32'(cpu_rdy), 32'd1);
    check("reset_active", 32'(dma_active), 32'd0);
    check("reset_done", 32'(dma_done), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Plain CPU write in IDLE passes straight through.
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_dout = 8'h3C;
    #1;
    check("idle_addr", 32'(bus_addr), 32'h2000);
    check("idle_dout", 32'(bus_dout), 32'h3C);
    check("idle_we", 32'(bus_we), 32'd1);
    check("idle_rdy", 32'(cpu_rdy), 32'd1);
    @(posedge clk); #1 idle_cpu();
    repeat (3) @(posedge clk);
    #1 check("idle_no_dma", 32'(dma_active), 32'd0);

    // Page 02, even parity in HALT, with a stray trigger mid-transfer.
    trigger(8'h02, 1'b0);
    repeat (50) @(posedge clk);
    #1 cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h05;
    @(posedge clk); #1 idle_cpu();
    wait_done("p02_done");
    // Re-trigger in the done cycle.
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h03;
    @(posedge clk); #1;
    check("p02_halt_len", 32'(halt_cnt), 32'd513);
    check("p02_writes", 32'(wr_cnt), 32'd256);
    check("p02_reads", 32'(rd_cnt), 32'd256);
    check("p02_first", 32'(first_byte), 32'h02);
    check("p02_last", 32'(last_byte), 32'hFD);
    check("p02_last_rd", 32'(last_rd), 32'h02FF);
    check("p02_page_kept", 32'(bad_page), 32'd0);
    check("p02_done_cnt", 32'(done_cnt), 32'd1);
    clear_stats(8'h03);
    idle_cpu();
    check("retrig_active", 32'(dma_active), 32'd1);
    wait_done("p03_done");
    repeat (3) @(posedge clk);
    #1;
    check("p03_writes", 32'(wr_cnt), 32'd256);
    check("p03_last", 32'(last_byte), 32'hFC);
    check("p03_done_cnt", 32'(done_cnt), 32'd1);

    // Odd parity in HALT adds one alignment cycle.
    trigger(8'h02, 1'b1);
    wait_done("align_done");
    @(posedge clk); #1;
    check("align_halt_len", 32'(halt_cnt), 32'd514);
    check("align_writes", 32'(wr_cnt), 32'd256);

    // Top page: no wrap into page 00.
    trigger(8'hFF, 1'b0);
    wait_done("pff_done");
    @(posedge clk); #1;
    check("pff_last_rd", 32'(last_rd), 32'hFFFF);
    check("pff_last", 32'(last_byte), 32'hFF);
    check("pff_first", 32'(first_byte), 32'h00);
    check("pff_no_0000", 32'(touch0), 32'd0);

    // Reset mid-transfer.
    trigger(8'h02, 1'b0);
    repeat (99) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_pass_addr", 32'(bus_addr), 32'(IDLE_ADDR));
    check("rst_pass_we", 32'(bus_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_stats(8'h02);
    repeat (600) @(posedge clk);
    #1;
    check("rst_no_oam_wr", 32'(oam_wr_any), 32'd0);
    check("rst_stay_idle", 32'(dma_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
